// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider: default widths and
// the control FSM state encoding. Imported by the datapath and the top level.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  // Default operand width and iteration counter width (2**CNT_W > WIDTH).
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_datapath.sv
// -----------------------------------------------------------------------------
// seq_divider_datapath
// Datapath of the restoring divider: partial remainder / quotient shift
// registers, latched divisor, trial subtractor, iteration counter and the
// result registers presented on the block outputs.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset (clears all registers)
//   load_i       accept an operation with a non-zero divisor
//   load_dz_i    accept an operation with a zero divisor (writes results now)
//   shift_sub_i  perform one shift / trial-subtract step
//   write_i      copy this step's quotient/remainder into the result registers
//   dividend_i   numerator operand
//   divisor_i    denominator operand
//   last_iter_o  the current step is the final one (counter == WIDTH-1)
//   quotient_o   result quotient
//   remainder_o  result remainder
// -----------------------------------------------------------------------------
module seq_divider_datapath
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             load_dz_i,
  input  logic             shift_sub_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_iter_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] qres_q, qres_d;
  logic [WIDTH-1:0] rres_q, rres_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  // One restoring step: shift the quotient MSB into the remainder, try to
  // subtract the divisor, keep the difference only if it did not borrow.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    // A set remainder MSB would mean the shifted value exceeds any divisor;
    // the partial remainder stays below the divisor so this never occurs,
    // but folding it in keeps the step correct on its own terms.
    fits      = ~trial[WIDTH] | rem_q[WIDTH];
    if (fits) begin
      rem_step = trial;
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = rem_shift;
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qres_d = qres_q;
    rres_d = rres_q;

    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (shift_sub_i) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Results are taken from the final step's outputs so they are valid on
    // the same edge that enters DONE.
    if (write_i) begin
      qres_d = quo_step;
      rres_d = rem_step[WIDTH-1:0];
    end

    // Divide by zero: all-ones quotient, dividend passed through as remainder.
    if (load_dz_i) begin
      dvs_d  = divisor_i;
      qres_d = '1;
      rres_d = dividend_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qres_q <= '0;
      rres_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qres_q <= qres_d;
      rres_q <= rres_d;
    end
  end

  assign last_iter_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient_o  = qres_q;
  assign remainder_o = rres_q;

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned multi-cycle restoring divider, one quotient bit per clock. Holds
// the control FSM (IDLE -> CALC -> DONE) and drives seq_divider_datapath.
// The start/busy/done handshake matches the sequential multiplier sharing the
// same ALU slot.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   rst          synchronous active-high reset, aborts any operation
//   start        request, sampled only in IDLE
//   dividend     numerator, latched on an accepted start
//   divisor      denominator, latched on an accepted start
//   busy         high in CALC and DONE
//   done         one-cycle pulse when results are valid
//   div_by_zero  set with done for a zero divisor, cleared on next accept
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_e state_q, state_d;
  logic   dbz_q, dbz_d;

  logic   load;
  logic   load_dz;
  logic   shift_sub;
  logic   write;
  logic   last_iter;
  logic   divisor_zero;

  assign divisor_zero = (divisor == '0);

  always_comb begin
    state_d   = state_q;
    dbz_d     = dbz_q;
    load      = 1'b0;
    load_dz   = 1'b0;
    shift_sub = 1'b0;
    write     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor_zero) begin
            // Result is known immediately; skip the iteration phase.
            load_dz = 1'b1;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            load    = 1'b1;
            dbz_d   = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        shift_sub = 1'b1;
        if (last_iter) begin
          write   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;

  seq_divider_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .load_dz_i   (load_dz),
    .shift_sub_i (shift_sub),
    .write_i     (write),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .last_iter_o (last_iter),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=32). Directed vectors come from a
// table; expected results go into a scoreboard queue when an operation is
// started and are compared by a monitor whenever done pulses. Hand-written
// sequences cover result holding, divide-by-zero and reset mid-calculation,
// followed by back-to-back random operations.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  int   n_checks      = 0;
  int   n_fail        = 0;
  bit   bb_mode       = 1'b0;
  int   ncyc          = 0;
  int   prev_done_cyc = -1;
  logic prev_done     = 1'b0;

  seq_divider #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending op.
  initial begin
    exp_t        e;
    logic [63:0] lhs;
    logic        ok;
    forever begin
      @(negedge clk);
      ncyc++;
      if (done === 1'b1) begin
        check("done_has_pending_op", {31'b0, done}, {31'b0, (sb.size() != 0)});
        check("done_not_consecutive", {31'b0, prev_done}, 32'd0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
          if (!e.dz) begin
            lhs = {32'b0, quotient} * {32'b0, e.b} + {32'b0, remainder};
            ok  = (lhs == {32'b0, e.a}) && (remainder < e.b);
            check("invariant", {31'b0, ok}, 32'd1);
          end
        end
        if (bb_mode && prev_done_cyc >= 0)
          check("done_period", 32'(ncyc - prev_done_cyc), 32'd34);
        prev_done_cyc = ncyc;
      end
      prev_done = done;
    end
  end

  // Start one operation, push its expected result and measure start-to-done
  // latency. Operands are scrambled right after acceptance.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input int lat);
    int   k;
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    k = 1;
    while (done !== 1'b1 && k < 3 * WIDTH) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{32'd154,        32'd11,         32'd14,         32'd0,      1'b0, LAT};
    vecs[1] = '{32'd14,         32'd11,         32'd1,          32'd3,      1'b0, LAT};
    vecs[2] = '{32'd5,          32'd7,          32'd0,          32'd5,      1'b0, LAT};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0, LAT};
    vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0, LAT};
    vecs[5] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,   1'b1, 1};
    vecs[6] = '{32'd9,          32'd3,          32'd3,          32'd0,      1'b0, LAT};
    vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,      1'b0, LAT};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

    // Divide-by-zero result must be held while idle.
    do_op(32'h55, 32'd0, 32'hFFFF_FFFF, 32'h55, 1'b1, 1);
    repeat (5) @(negedge clk);
    check("dz_hold_flag", {31'b0, div_by_zero}, 32'd1);
    check("dz_hold_quotient", quotient, 32'hFFFF_FFFF);
    check("dz_hold_remainder", remainder, 32'h55);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Start 100/7, poke start and operands mid-run, then reset mid-run.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("calc_busy", {31'b0, busy}, 32'd1);
    check("calc_dbz_cleared", {31'b0, div_by_zero}, 32'd0);
    check("calc_quotient_held", quotient, 32'hFFFF_FFFF);
    check("calc_remainder_held", remainder, 32'h55);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'd77;
    divisor  = 32'd0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_still_idle", {31'b0, busy}, 32'd0);
    do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT);

    // Back-to-back random operations.
    prev_done_cyc = -1;
    bb_mode       = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) b = 32'($urandom_range(1, 1000));
      else                           b = $urandom;
      if (b == 32'd0) b = 32'd1;
      do_op(a, b, a / b, a % b, 1'b0, LAT);
    end
    bb_mode = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Unsigned multi-cycle restoring divider; the division counterpart of the team's sequential shift-add multiplier, sharing its ALU slot.
Computes quotient and remainder one bit per clock via shift-left/trial-subtract, driven by an internal control FSM over a separate datapath.
Exposes a start/busy/done handshake to the ALU control so divide and multiply ops sequence the same way.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>= 2)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
dividend  in  WIDTH  numerator, latched on accepted start
divisor  in  WIDTH  denominator, latched on accepted start
busy  out  1  high while in CALC or DONE
done  out  1  one-cycle pulse when results valid
div_by_zero  out  1  set with done when latched divisor was 0; held until next accepted start
quotient  out  WIDTH  result quotient, held until next accepted start
remainder  out  WIDTH  result remainder, held until next accepted start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0. Overrides everything, including mid-calculation; in-flight op is discarded, no done pulse.
- States: IDLE, CALC, DONE (encoding in package).
- IDLE: start=1 at edge E0 -> operands latched. If divisor!=0: rem_reg(WIDTH+1 bits)=0, quo_reg=dividend, counter=0, div_by_zero cleared -> CALC. If divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1 -> DONE.
- CALC, each edge: {rem_reg,quo_reg} shifted left 1 (quo MSB into rem LSB); trial=rem_shifted - {0,divisor} (WIDTH+1 bits); if trial MSB=0, rem_reg=trial and quo LSB=1, else rem_reg=rem_shifted and quo LSB=0; counter+=1. Edge where counter==WIDTH-1 -> DONE.
- Exactly WIDTH CALC edges (E1..E_WIDTH). done=1 during the cycle after E_WIDTH; latency start-edge to done-high = WIDTH+1 cycles (33 for default); divide-by-zero: done high the cycle after E0.
- DONE: done=1 for exactly one cycle; quotient/remainder outputs updated from quo_reg/rem_reg[WIDTH-1:0] on entry; next edge -> IDLE unconditionally. start during DONE ignored.
- busy=1 in CALC and DONE, 0 in IDLE; a start may be accepted on the first IDLE cycle after DONE (back-to-back period WIDTH+2).
- start while busy ignored; operand input changes after E0 have no effect.
- Outputs quotient/remainder/div_by_zero change only on entry to DONE or on reset; stable otherwise.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, remainder < divisor.

Decomposition:
- Shared package: state typedef/localparams (ST_IDLE, ST_CALC, ST_DONE), default WIDTH/CNT_W constants.
- One sub-module: seq_divider_datapath (rem/quo registers, subtractor, counter; controls load, shift_sub, write; status last_iter), mirroring the multiplier's datapath/control split; seq_divider top holds the FSM.

Test Plan:
- After reset, start with dividend=154, divisor=11 -> done exactly 33 cycles after start edge, quotient=14, remainder=0, div_by_zero=0 (inverse of multiplier case 11*14).
- dividend=14, divisor=11 -> quotient=1, remainder=3; dividend=5, divisor=7 -> quotient=0, remainder=5.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; divisor=0xFFFFFFFF -> quotient=1, remainder=0.
- divisor=0, dividend=0x1234 -> done on next cycle, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x1234; next valid op clears div_by_zero.
- Start 100/7, pulse start with 9/3 and change operands at cycle 10, rst=1 at cycle 20 -> no done, all outputs 0, busy=0; then 9/3 -> quotient=3, remainder=0.
- Random 1000 operand pairs, back-to-back starts on first IDLE cycle -> each result matches invariant, done period = 34 cycles, done never two consecutive cycles.
